// File: rtl/cache_fill_ctrl.sv
// Cache miss refill controller: issues WORDS pipelined word reads for the aligned block
// and steers each returning word into the data array, loading the tag on the last word.
module cache_fill_ctrl #(
    parameter int WORDS  = 8,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              mem_data_valid,
    input  logic [DATA_W-1:0] mem_data,
    output logic              fsm_busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_address,
    output logic [ADDR_W-1:0] fill_address,
    output logic              write_data_array,
    output logic              write_tag_array,
    output logic [WORDS-1:0]  word_enable,
    output logic [DATA_W-1:0] data_out,
    output logic              fsm_state_dbg
);
    localparam int IDX_W = $clog2(WORDS);
    localparam int CNT_W = IDX_W + 1;
    localparam int SH_W  = $clog2(DATA_W / 8);
    localparam int OFF_W = IDX_W + SH_W;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

    // Handshake: memory accepts a request every cycle mem_req=1 and returns data in
    // request order, one word per cycle mem_data_valid=1; there is no back-pressure.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]   recv_cnt_q, recv_cnt_d;
    logic [ADDR_W-1:0]  fill_addr_q, fill_addr_d;
    logic [IDX_W-1:0]   issue_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            fill_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            fill_addr_q <= fill_addr_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        issue_cnt_d      = issue_cnt_q;
        recv_cnt_d       = recv_cnt_q;
        fill_addr_d      = fill_addr_q;
        fsm_busy         = 1'b0;
        mem_req          = 1'b0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        word_enable      = '0;
        case (state_q)
            S_IDLE: begin
                if (miss_detected) begin
                    fill_addr_d = {miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                    state_d     = S_FILL;
                end
            end
            S_FILL: begin
                fsm_busy = 1'b1;
                if (issue_cnt_q < FULL) begin
                    mem_req     = 1'b1;
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                end
                // Words beyond the block are dropped; the count never wraps inside a fill.
                if (mem_data_valid && (recv_cnt_q < FULL)) begin
                    write_data_array = 1'b1;
                    word_enable      = WORDS'(1) << recv_cnt_q[IDX_W-1:0];
                    recv_cnt_d       = recv_cnt_q + CNT_W'(1);
                    if (recv_cnt_q == LAST) begin
                        write_tag_array = 1'b1;
                        state_d         = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Once all requests are out the address holds on the last word of the block.
    assign issue_idx     = (issue_cnt_q < FULL) ? issue_cnt_q[IDX_W-1:0] : IDX_W'(WORDS - 1);
    assign mem_address   = fill_addr_q + (ADDR_W'(issue_idx) << SH_W);
    assign fill_address  = fill_addr_q;
    assign data_out      = rst ? mem_data : '0;
    assign fsm_state_dbg = state_q;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Randomised bench for cache_fill_ctrl: a 4-cycle pipelined memory, a block-level
// reference model feeding an expected queue, and a per-cycle monitor that pops and compares.
module tb_cache_fill_ctrl;
    localparam int WORDS  = 8;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int L      = 4;

    typedef struct packed {
        logic        busy;
        logic        req;
        logic [15:0] addr;
        logic [15:0] fill;
        logic        wr;
        logic        tag;
        logic [7:0]  we;
        logic [15:0] data;
        logic        c_addr;
        logic        c_data;
    } exp_t;
    localparam int W = $bits(exp_t);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b0;
    logic              miss_detected = 1'b0;
    logic [ADDR_W-1:0] miss_address = '0;
    logic              spur_valid = 1'b0;
    logic              pipe_valid = 1'b0;
    logic              mem_data_valid;
    logic [DATA_W-1:0] mem_data = '0;
    logic              fsm_busy, mem_req, write_data_array, write_tag_array, fsm_state_dbg;
    logic [ADDR_W-1:0] mem_address, fill_address;
    logic [WORDS-1:0]  word_enable;
    logic [DATA_W-1:0] data_out;

    assign mem_data_valid = pipe_valid | spur_valid;

    cache_fill_ctrl #(.WORDS(WORDS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .mem_data_valid   (mem_data_valid),
        .mem_data         (mem_data),
        .fsm_busy         (fsm_busy),
        .mem_req          (mem_req),
        .mem_address      (mem_address),
        .fill_address     (fill_address),
        .write_data_array (write_data_array),
        .write_tag_array  (write_tag_array),
        .word_enable      (word_enable),
        .data_out         (data_out),
        .fsm_state_dbg    (fsm_state_dbg)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- main memory ----------------
    logic [15:0] mem_arr [int];

    function automatic logic [15:0] get_word(input logic [15:0] a);
        if (!mem_arr.exists(int'(a))) mem_arr[int'(a)] = 16'($urandom);
        return mem_arr[int'(a)];
    endfunction

    int          mcyc = 0;
    logic        pend_v [0:63] = '{default: 1'b0};
    logic [15:0] pend_a [0:63];

    always @(negedge clk) begin
        if (mem_req) begin
            pend_v[(mcyc + L) % 64] = 1'b1;
            pend_a[(mcyc + L) % 64] = mem_address;
        end
        pipe_valid = pend_v[mcyc % 64];
        mem_data   = pipe_valid ? get_word(pend_a[mcyc % 64]) : 16'($urandom);
        pend_v[mcyc % 64] = 1'b0;
        mcyc++;
    end

    // ---------------- reference model ----------------
    bit          m_busy = 0;
    int          m_iss = 0;
    int          m_rcv = 0;
    logic [15:0] m_base = '0;
    logic [W-1:0] exp_q[$];

    always @(negedge clk) begin
        exp_t e;
        #1;
        e = '0;
        if (!rst) begin
            m_busy = 0; m_iss = 0; m_rcv = 0; m_base = '0;
            e.c_addr = 1'b1;
            e.c_data = 1'b1;
        end else if (!m_busy) begin
            e.fill = m_base;
            if (miss_detected) begin
                m_base = miss_address & 16'hFFF0;
                m_iss = 0; m_rcv = 0; m_busy = 1;
            end
        end else begin
            e.busy = 1'b1;
            e.fill = m_base;
            if (m_iss < WORDS) begin
                e.req = 1'b1;
                e.c_addr = 1'b1;
                e.addr = m_base + 16'(2 * m_iss);
                m_iss++;
            end
            if (mem_data_valid && m_rcv < WORDS) begin
                e.wr = 1'b1;
                e.c_data = 1'b1;
                e.we = 8'(1 << m_rcv);
                e.data = get_word(m_base + 16'(2 * m_rcv));
                e.tag = (m_rcv == WORDS - 1);
                m_rcv++;
                if (m_rcv == WORDS) m_busy = 0;
            end
        end
        exp_q.push_back(W'(e));
    end

    // ---------------- monitor / scoreboard ----------------
    logic [15:0] tb_darr [0:7];

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() != 0) begin
            e = exp_t'(exp_q.pop_front());
            chk("fsm_busy", 32'(fsm_busy), 32'(e.busy));
            chk("mem_req", 32'(mem_req), 32'(e.req));
            chk("write_data_array", 32'(write_data_array), 32'(e.wr));
            chk("write_tag_array", 32'(write_tag_array), 32'(e.tag));
            chk("word_enable", 32'(word_enable), 32'(e.we));
            chk("fill_address", 32'(fill_address), 32'(e.fill));
            if (e.c_addr) chk("mem_address", 32'(mem_address), 32'(e.addr));
            if (e.c_data) chk("data_out", 32'(data_out), 32'(e.data));
        end
        if (write_data_array)
            for (int i = 0; i < WORDS; i++)
                if (word_enable[i]) tb_darr[i] = data_out;
    end

    // ---------------- driver tasks ----------------
    task automatic issue_miss(input logic [15:0] a);
        miss_detected = 1'b1;
        miss_address  = a;
        @(negedge clk);
        miss_detected = 1'b0;
        spur_valid    = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while (m_busy && n < maxc) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (m_busy) begin
            n_err++;
            $display("FAIL wait_idle: fill still busy after %0d cycles, required idle", maxc);
        end
    endtask

    task automatic idle_cycles(input int n, input bit spur);
        for (int i = 0; i < n; i++) begin
            spur_valid = spur ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        spur_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle_cycles(4, 0);

        // Reset in idle, then release with no miss.
        rst = 1'b0;
        idle_cycles(2, 0);
        rst = 1'b1;
        idle_cycles(4, 0);

        // Single fill with known data, then read back the captured data array.
        for (int i = 0; i < WORDS; i++) mem_arr[int'(16'h1230) + 2 * i] = 16'hA000 + 16'(i);
        issue_miss(16'h1236);
        wait_idle(40);
        for (int i = 0; i < WORDS; i++) chk("darr_readback", 32'(tb_darr[i]), 32'(16'hA000 + 16'(i)));

        // Spurious valids in idle, miss toggling during a fill.
        idle_cycles(6, 1);
        issue_miss(16'($urandom));
        for (int n = 0; n < 40 && m_busy; n++) begin
            miss_detected = 1'($urandom_range(0, 1));
            miss_address  = 16'($urandom);
            @(negedge clk);
        end
        miss_detected = 1'b0;
        wait_idle(40);
        spur_valid = 1'b1;
        @(negedge clk);
        spur_valid = 1'b0;
        idle_cycles(3, 1);

        // Reset after the third data write; the next miss refills from word 0.
        issue_miss(16'h5552);
        for (int n = 0; n < 40 && m_rcv < 3; n++) @(negedge clk);
        rst = 1'b0;
        idle_cycles(2, 0);
        rst = 1'b1;
        idle_cycles(10, 0);
        issue_miss(16'h5552);
        wait_idle(40);
        idle_cycles(2, 0);

        // Back-to-back: miss held high across completion with a new address.
        miss_detected = 1'b1;
        miss_address  = 16'h2004;
        @(negedge clk);
        miss_address  = 16'h4008;
        for (int n = 0; n < 40 && !(m_busy && m_base == 16'h4000); n++) @(negedge clk);
        miss_detected = 1'b0;
        #2;
        chk("b2b_fill_address", 32'(fill_address), 32'h4000);
        @(negedge clk);
        wait_idle(40);
        idle_cycles(2, 0);

        // Randomised fills with spurious idle valids.
        for (int k = 0; k < 15; k++) begin
            idle_cycles($urandom_range(0, 3), 1);
            issue_miss(16'($urandom));
            wait_idle(40);
        end

        idle_cycles(5, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
